axi_stream_framer: RTL
======================

Name: axi_stream_framer

Overview:
- Streaming stage directly downstream of the block-RAM AXI FIFO. Consumes its raw word stream (no tlast) and produces packetised AXI-stream output.
- o_tlast is asserted every frame_len words, or early when the input goes idle for timeout cycles (flush of a short frame).
- Holds exactly one word back so that tlast can be attached retroactively on timeout.
- Full-rate throughput under continuous input and no backpressure.

Parameters:
- WIDTH, 32, data width in bits.
- LEN_WIDTH, 16, width of frame_len and of the in-frame word counter.
- TMO_WIDTH, 16, width of timeout and of the idle timer.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush, same effect as reset on all state
- i_tdata  input  WIDTH  input data, from FIFO o_tdata
- i_tvalid  input  1  input valid
- i_tready  output  1  input ready
- o_tdata  output  WIDTH  registered output data
- o_tlast  output  1  registered end-of-frame marker
- o_tvalid  output  1  registered output valid
- o_tready  input  1  downstream ready
- frame_len  input  LEN_WIDTH  words per full frame; 0 is treated as 1
- timeout  input  TMO_WIDTH  idle cycles before a short-frame flush; 0 disables flushing
- frame_count  output  16  frames emitted, wraps modulo 2^16
- short_frames  output  16  frames terminated by timeout, wraps modulo 2^16

Behaviour:
- Reset/clear values: o_tvalid=0, o_tlast=0, o_tdata=0, hold_valid=0, cnt=0, timer=0, frame_count=0, short_frames=0. Clear has priority over all other activity in the same cycle.
- Storage: one hold register (hold_valid, hold_data) plus one output register.
  - out_ready = o_tready | ~o_tvalid.
  - The output register loads only when out_ready is high. It is otherwise stable; AXI rules apply, and o_tdata/o_tlast do not change while o_tvalid & ~o_tready.
- Frame length latch: len_reg = max(frame_len,1), captured when a word is accepted into hold while cnt==0. frame_len and timeout changes take effect only at frame start.
- cnt: number of current-frame words already moved to the output register. The held word is frame index cnt.
- Release condition (held word moves to the output register), evaluated only when hold_valid & out_ready:
  - last_by_len = (cnt == len_reg-1). Release with tlast=1, regardless of input.
  - Else, if i_tvalid is high: release with tlast=0.
  - Else, if timeout != 0 and timer == timeout: release with tlast=1 and short_frames += 1.
- On release: cnt <= tlast ? 0 : cnt+1. If tlast, frame_count += 1.
- i_tready = ~hold_valid | release. A word is accepted into hold on the same edge the previous held word is released, giving full rate.
- Idle timer:
  - Cleared when a word is accepted or when hold is empty.
  - Otherwise increments each cycle, saturating at timeout.
  - Keeps counting while out_ready is low. A pending timeout flush fires on the first cycle out_ready returns, unless i_tvalid has risen by then; in that case a normal tlast=0 release occurs.
- Latency: a word accepted at edge k can be in the output register at the earliest from edge k+1, i.e. o_tvalid high in the cycle after that edge.
- timeout=0 with a partial frame: the last received word stays held indefinitely until more input arrives. This is intentional.
- Boundary cases:
  - cnt never exceeds len_reg-1.
  - Counter wrap at 2^16 is silent.
  - When frame_len=1, every word carries tlast=1 and the timer never fires, because last_by_len holds.
- Reset or clear mid-frame: held and output words are discarded with no tlast emitted. The next accepted word starts a new frame with frame_len re-sampled.

Test Plan:
- frame_len=4, timeout=0, o_tready=1, send words 1..8 back-to-back -> o_tdata 1..8 on consecutive cycles, o_tlast on 4 and 8, frame_count=2, short_frames=0, i_tready held high throughout.
- frame_len=4, timeout=10, send 1,2,3 then idle -> 1,2 emitted with tlast=0; 3 emitted with tlast=1 after 10 idle cycles; short_frames=1. Then send 4..7 -> tlast on 7 (new frame of 4).
- frame_len=4, timeout=0, send 1,2,3 then idle 100 cycles -> only 1,2 emitted; 3 held. Send 4 -> 3 emitted, then 4 emitted with tlast=1.
- frame_len=3, 30 words, o_tready toggled pseudo-randomly (~50%) -> all words in order, no loss or duplication, tlast on every 3rd word, o_tdata/o_tlast stable while stalled, frame_count=10.
- frame_len=0 -> every word has tlast=1. frame_len changed from 4 to 2 mid-frame -> current frame still ends at 4 words; next frame has 2 words.
- Assert clear after 2 words of a 4-word frame -> next cycle o_tvalid=0, counters=0, i_tready=1. Next words 9..12 form a fresh 4-word frame with tlast on 12.

Source files
------------

// File: rtl/axi_stream_framer.sv
// Packetises a raw word stream into AXI-stream frames of frame_len words.
// A short frame is closed with tlast when the input idles for timeout cycles.
module axi_stream_framer #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16,
    parameter int TMO_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     i_tdata,
    input  logic                 i_tvalid,
    output logic                 i_tready,
    output logic [WIDTH-1:0]     o_tdata,
    output logic                 o_tlast,
    output logic                 o_tvalid,
    input  logic                 o_tready,
    input  logic [LEN_WIDTH-1:0] frame_len,
    input  logic [TMO_WIDTH-1:0] timeout,
    output logic [15:0]          frame_count,
    output logic [15:0]          short_frames
);

    logic                 hold_valid;
    logic [WIDTH-1:0]     hold_data;
    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [TMO_WIDTH-1:0] timer;
    logic [TMO_WIDTH-1:0] tmo_reg;

    logic out_ready;
    logic last_by_len;
    logic timeout_hit;
    logic release_ok;
    logic rel_last;
    logic rel_short;
    logic accept;
    logic frame_start;

    always_comb begin
        out_ready   = o_tready | ~o_tvalid;
        last_by_len = (cnt == len_reg - LEN_WIDTH'(1));
        timeout_hit = (tmo_reg != '0) && (timer == tmo_reg);
        release_ok  = hold_valid & out_ready & (last_by_len | i_tvalid | timeout_hit);
        rel_last    = last_by_len | (~i_tvalid & timeout_hit);
        rel_short   = ~last_by_len & ~i_tvalid & timeout_hit;
        i_tready    = ~hold_valid | release_ok;
        accept      = i_tvalid & i_tready;
        // The incoming word is frame index 0 when the hold slot was empty
        // (cnt is 0 then) or the word leaving it closes the frame.
        frame_start = accept & (~hold_valid | (release_ok & rel_last));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            o_tdata      <= '0;
            o_tlast      <= 1'b0;
            o_tvalid     <= 1'b0;
            cnt          <= '0;
            len_reg      <= LEN_WIDTH'(1);
            timer        <= '0;
            tmo_reg      <= '0;
            frame_count  <= '0;
            short_frames <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= i_tdata;
            end else if (release_ok) begin
                hold_valid <= 1'b0;
            end

            if (frame_start) begin
                len_reg <= (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
                tmo_reg <= timeout;
            end

            if (out_ready) begin
                o_tvalid <= release_ok;
                if (release_ok) begin
                    o_tdata <= hold_data;
                    o_tlast <= rel_last;
                end
            end

            if (release_ok) begin
                cnt <= rel_last ? '0 : cnt + LEN_WIDTH'(1);
                if (rel_last)
                    frame_count <= frame_count + 16'd1;
                if (rel_short)
                    short_frames <= short_frames + 16'd1;
            end

            // Idle timer runs on even while the output is stalled
            if (accept || release_ok || !hold_valid)
                timer <= '0;
            else if (timer != tmo_reg)
                timer <= timer + TMO_WIDTH'(1);
        end
    end

endmodule
